// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized rising edges of ro_in over a
// gate window of GATE_CYCLES clk cycles and publishes the count with a one-cycle strobe.
module ro_freq_meter #(
  parameter int CNT_W       = 16,
  parameter int GATE_CYCLES = 1000,
  parameter int GATE_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             count_valid,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             dbg_state
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t              state;
  state_t              state_nxt;
  logic                sync_s1;
  logic                sync_s2;
  logic                prev;
  logic                rise;
  logic [GATE_W-1:0]   gate;
  logic [CNT_W-1:0]    edge_cnt;
  logic                ovf_i;
  logic                at_max;
  logic                terminal;

  // Edge detector runs in every state so prev is already settled when a window opens.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_s1 <= 1'b0;
      sync_s2 <= 1'b0;
      prev    <= 1'b0;
    end else begin
      sync_s1 <= ro_in;
      sync_s2 <= sync_s1;
      prev    <= sync_s2;
    end
  end

  assign rise      = sync_s2 & ~prev;
  assign at_max    = (edge_cnt == CNT_MAX);
  assign terminal  = (state == MEASURE) && (gate == '0);
  assign busy      = (state == MEASURE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MEASURE;
      MEASURE: if (terminal && !cont) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The terminal cycle folds its own rise into the published count, then reloads
  // so a continuous run starts the next window with no gap cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gate        <= '0;
      edge_cnt    <= '0;
      ovf_i       <= 1'b0;
      count       <= '0;
      overflow    <= 1'b0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= terminal;
      if (state == IDLE) begin
        if (start) begin
          gate     <= GATE_LOAD;
          edge_cnt <= '0;
          ovf_i    <= 1'b0;
        end
      end else if (terminal) begin
        count    <= (rise && !at_max) ? edge_cnt + CNT_W'(1) : edge_cnt;
        overflow <= ovf_i | (rise & at_max);
        gate     <= GATE_LOAD;
        edge_cnt <= '0;
        ovf_i    <= 1'b0;
      end else begin
        gate <= gate - GATE_W'(1);
        if (rise) begin
          if (at_max) ovf_i <= 1'b1;
          else        edge_cnt <= edge_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: a 16-cycle-gate instance and a 4-bit saturating
// instance share clock, reset and the synthetic ring-oscillator waveform.
module tb_ro_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ro_in = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        busy;
  logic        cv;
  logic [15:0] count;
  logic        ovf;
  logic        dbg;

  logic        start_b = 1'b0;
  logic        busy_b;
  logic        cv_b;
  logic [3:0]  count_b;
  logic        ovf_b;
  logic        dbg_b;

  int total = 0;
  int bad = 0;
  int ro_per = 0;
  int ro_ph = 0;

  ro_freq_meter #(.CNT_W(16), .GATE_CYCLES(16), .GATE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .start(start), .cont(cont),
    .busy(busy), .count_valid(cv), .count(count), .overflow(ovf), .dbg_state(dbg)
  );

  ro_freq_meter #(.CNT_W(4), .GATE_CYCLES(64), .GATE_W(8)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .start(start_b), .cont(1'b0),
    .busy(busy_b), .count_valid(cv_b), .count(count_b), .overflow(ovf_b), .dbg_state(dbg_b)
  );

  always #5 clk = ~clk;

  // Oscillator model: period ro_per clk cycles, high for the first half; 0 = held low.
  always @(negedge clk) begin
    if (ro_per == 0) begin
      ro_in = 1'b0;
      ro_ph = 0;
    end else begin
      ro_ph = (ro_ph + 1) % ro_per;
      ro_in = (ro_ph < ro_per / 2);
    end
  end

  // Steps to the next count_valid on the main instance; n = cycles stepped.
  task automatic wait_next(output int n, output int busy_n);
    n = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (busy === 1'b1 && cv !== 1'b1) busy_n++;
    end while (cv !== 1'b1 && n < 200);
  endtask

  task automatic wait_next_b(output int n);
    n = 0;
    do begin
      @(negedge clk);
      start_b = 1'b0;
      n++;
    end while (cv_b !== 1'b1 && n < 300);
  endtask

  task automatic settle(input int per);
    ro_per = per;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (cv !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", cv); end
    total++; if (count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    total++; if (dbg !== 1'b0) begin bad++; $display("FAIL reset_state got=%b exp=0", dbg); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle_input;
    int n, bn;
    settle(0);
    @(negedge clk) start = 1'b1;
    wait_next(n, bn);
    total++; if (n != 17) begin bad++; $display("FAIL idle_latency got=%0d exp=17", n); end
    total++; if (bn != 16) begin bad++; $display("FAIL idle_busy_cycles got=%0d exp=16", bn); end
    total++; if (count !== 16'd0) begin bad++; $display("FAIL idle_count got=%0d exp=0", count); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL idle_ovf got=%b exp=0", ovf); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_periods;
    int n, bn;
    settle(4);
    @(negedge clk) start = 1'b1;
    wait_next(n, bn);
    total++; if (n != 17) begin bad++; $display("FAIL p4_latency got=%0d exp=17", n); end
    total++; if (count !== 16'd4) begin bad++; $display("FAIL p4_count got=%0d exp=4", count); end
    settle(8);
    total++; if (count !== 16'd4) begin bad++; $display("FAIL p4_hold got=%0d exp=4", count); end
    @(negedge clk) start = 1'b1;
    wait_next(n, bn);
    total++; if (count !== 16'd2) begin bad++; $display("FAIL p8_count got=%0d exp=2", count); end
  endtask

  task automatic test_saturate;
    int n;
    settle(2);
    @(negedge clk) start_b = 1'b1;
    wait_next_b(n);
    total++; if (n != 65) begin bad++; $display("FAIL sat_latency got=%0d exp=65", n); end
    total++; if (count_b !== 4'd15) begin bad++; $display("FAIL sat_count got=%0d exp=15", count_b); end
    total++; if (ovf_b !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%b exp=1", ovf_b); end
    settle(0);
    @(negedge clk) start_b = 1'b1;
    repeat (30) begin
      @(negedge clk);
      start_b = 1'b0;
    end
    total++; if (ovf_b !== 1'b1) begin bad++; $display("FAIL sat_ovf_hold got=%b exp=1", ovf_b); end
    total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL sat_busy got=%b exp=1", busy_b); end
    wait_next_b(n);
    total++; if (count_b !== 4'd0) begin bad++; $display("FAIL sat_clear_count got=%0d exp=0", count_b); end
    total++; if (ovf_b !== 1'b0) begin bad++; $display("FAIL sat_clear_ovf got=%b exp=0", ovf_b); end
  endtask

  task automatic test_continuous;
    int n, bn, extra;
    settle(4);
    cont = 1'b1;
    @(negedge clk) start = 1'b1;
    wait_next(n, bn);
    total++; if (n != 17) begin bad++; $display("FAIL cont_first got=%0d exp=17", n); end
    total++; if (count !== 16'd4) begin bad++; $display("FAIL cont_count0 got=%0d exp=4", count); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL cont_busy got=%b exp=1", busy); end
    for (int k = 1; k < 3; k++) begin
      wait_next(n, bn);
      total++; if (n != 16) begin bad++; $display("FAIL cont_period%0d got=%0d exp=16", k, n); end
      total++; if (count !== 16'd4) begin bad++; $display("FAIL cont_count%0d got=%0d exp=4", k, count); end
    end
    cont = 1'b0;
    wait_next(n, bn);
    total++; if (n != 16) begin bad++; $display("FAIL cont_last got=%0d exp=16", n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_stop_busy got=%b exp=0", busy); end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (cv === 1'b1) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL cont_extra got=%0d exp=0", extra); end
  endtask

  task automatic test_back_to_back;
    int n, bn;
    settle(8);
    @(negedge clk) start = 1'b1;
    wait_next(n, bn);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    wait_next(n, bn);
    total++; if (n != 16) begin bad++; $display("FAIL b2b_latency got=%0d exp=16", n); end
    total++; if (count !== 16'd2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", count); end
  endtask

  task automatic test_start_ignored;
    int first, strobes;
    settle(8);
    @(negedge clk) start = 1'b1;
    first = 0;
    strobes = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = (n == 3 || n == 10);
      if (cv === 1'b1) begin
        strobes++;
        if (first == 0) first = n;
      end
    end
    start = 1'b0;
    total++; if (first != 17) begin bad++; $display("FAIL ign_latency got=%0d exp=17", first); end
    total++; if (strobes != 1) begin bad++; $display("FAIL ign_strobes got=%0d exp=1", strobes); end
    total++; if (count !== 16'd2) begin bad++; $display("FAIL ign_count got=%0d exp=2", count); end
  endtask

  task automatic test_reset_mid;
    int n, bn, extra;
    settle(4);
    @(negedge clk) start = 1'b1;
    repeat (8) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    total++; if (count !== 16'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", count); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rmid_ovf got=%b exp=0", ovf); end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (cv === 1'b1) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL rmid_strobe got=%0d exp=0", extra); end
    @(negedge clk) start = 1'b1;
    wait_next(n, bn);
    total++; if (n != 17) begin bad++; $display("FAIL rmid_restart_lat got=%0d exp=17", n); end
    total++; if (count !== 16'd4) begin bad++; $display("FAIL rmid_restart_count got=%0d exp=4", count); end
  endtask

  initial begin
    test_reset;
    test_idle_input;
    test_periods;
    test_saturate;
    test_continuous;
    test_back_to_back;
    test_start_ignored;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
